// File: rtl/uart_rx_bit_sampler.sv
// uart_rx_bit_sampler -- UART receive front end running on the x4 baud-tick clock.
// Latency: oDATA_REQ rises 38 (STOP_BITS=1) / 42 (STOP_BITS=2) cycles after the start-detect edge.
// Backpressure: none; request pulses are fire-and-forget, oDATA is held until the next frame completes.
//
// Optional build macro: UART_RX_MAJORITY_EN
//   undefined : every bit is a single sample taken at phase 1 of the bit
//   defined   : every bit is the 2-of-3 majority of phases 0,1,2, decided at phase 2
//
// Ports
//   b_bd_clock  in   1  baud-tick clock, 4 ticks per bit
//   inRESET     in   1  asynchronous active-low reset
//   iUART_RXD   in   1  raw serial line, idle high, asynchronous to b_bd_clock
//   oDATA       out  8  last received byte, stable from oDATA_REQ until the next frame completes
//   oFRAME_ERR  out  1  a stop bit of the last frame was sampled low; updated together with oDATA
//   oDATA_REQ   out  1  single-cycle pulse: oDATA / oFRAME_ERR are valid
//   oIDLE_REQ   out  1  single-cycle pulse: receiver returned to IDLE after a frame
//   oBUSY       out  1  receiver is in any state other than IDLE
//
// Parameter STOP_BITS: number of stop bits checked. 1 selects one stop bit; any
// other value is treated as 2.

module uart_rx_bit_sampler #(
  parameter int STOP_BITS = 1
) (
  input  logic       b_bd_clock,
  input  logic       inRESET,
  input  logic       iUART_RXD,
  output logic [7:0] oDATA,
  output logic       oFRAME_ERR,
  output logic       oDATA_REQ,
  output logic       oIDLE_REQ,
  output logic       oBUSY
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_DONE    = 3'd4,
    ST_BRKWAIT = 3'd5
  } state_t;

  // Two-flop synchroniser on the raw line; both flops reset to the idle level
  // so that reset release never looks like a falling start edge.
  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       rxd_s;

  state_t     state_q, state_d;
  logic [1:0] phase_q, phase_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] sr_q, sr_d;
  logic       err_q, err_d;
  logic       stop_idx_q, stop_idx_d;   // 0: first stop bit, 1: second stop bit
  logic       idle_pend_q, idle_pend_d; // IDLE was just entered from DONE/BRKWAIT

  logic [7:0] data_q, data_d;
  logic       frame_err_q, frame_err_d;
  logic       data_req_q, data_req_d;
  logic       idle_req_q, idle_req_d;
  logic       busy_q, busy_d;

  logic       stop_last;
  logic       err_fin;

`ifdef UART_RX_MAJORITY_EN
  // Samples taken at phase 0 and phase 1 of the current bit; phase 2 is the live rxd_s.
  logic [1:0] smp_q, smp_d;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
`endif

  assign rxd_s     = sync2_q;
  assign stop_last = (STOP_BITS == 1) || stop_idx_q;

  always_comb begin
    sync1_d     = iUART_RXD;
    sync2_d     = sync1_q;
    state_d     = state_q;
    phase_d     = phase_q + 2'd1;
    bit_cnt_d   = bit_cnt_q;
    sr_d        = sr_q;
    err_d       = err_q;
    stop_idx_d  = stop_idx_q;
    idle_pend_d = idle_pend_q;
    data_d      = data_q;
    frame_err_d = frame_err_q;
    data_req_d  = 1'b0;
    idle_req_d  = 1'b0;
    err_fin     = err_q;
`ifdef UART_RX_MAJORITY_EN
    smp_d = smp_q;
    if (phase_q == 2'd0) smp_d[0] = rxd_s;
    if (phase_q == 2'd1) smp_d[1] = rxd_s;
`endif

    case (state_q)
      ST_IDLE: begin
        phase_d = 2'd1;
        // The idle pulse is emitted in the first IDLE cycle, even if a new
        // start edge is detected in that very cycle.
        if (idle_pend_q) begin
          idle_req_d  = 1'b1;
          idle_pend_d = 1'b0;
        end
        // The sample that sees the line low counts as phase 0 of the start bit.
        if (!rxd_s) begin
          state_d    = ST_START;
          err_d      = 1'b0;
          stop_idx_d = 1'b0;
        end
      end

      ST_START: begin
`ifdef UART_RX_MAJORITY_EN
        // Phase 0 is known low; abort unless at least one of phases 1,2 is low too.
        if (phase_q == 2'd2 && smp_q[1] && rxd_s) begin
          state_d = ST_IDLE;
        end
`else
        if (phase_q == 2'd1 && rxd_s) begin
          state_d = ST_IDLE;
        end
`endif
        if (phase_q == 2'd3) begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'd0;
        end
      end

      ST_DATA: begin
`ifdef UART_RX_MAJORITY_EN
        if (phase_q == 2'd2) begin
          sr_d = {maj3(smp_q[0], smp_q[1], rxd_s), sr_q[7:1]};
        end
`else
        if (phase_q == 2'd1) begin
          sr_d = {rxd_s, sr_q[7:1]};
        end
`endif
        if (phase_q == 2'd3) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end
      end

      ST_STOP: begin
`ifdef UART_RX_MAJORITY_EN
        // The last stop bit leaves at phase 1 so DONE lands on its phase 2,
        // where the majority vote is completed; frame timing is unchanged.
        if (phase_q == 2'd1 && stop_last) begin
          state_d = ST_DONE;
        end
        if (phase_q == 2'd2 && !stop_last) begin
          err_d      = err_q | ~maj3(smp_q[0], smp_q[1], rxd_s);
          stop_idx_d = 1'b1;
        end
`else
        if (phase_q == 2'd1) begin
          err_d = err_q | ~rxd_s;
          if (stop_last) begin
            state_d = ST_DONE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
`endif
      end

      ST_DONE: begin
`ifdef UART_RX_MAJORITY_EN
        err_fin = err_q | ~maj3(smp_q[0], smp_q[1], rxd_s);
`endif
        data_d      = sr_q;
        frame_err_d = err_fin;
        data_req_d  = 1'b1;
        err_d       = err_fin;
        if (err_fin) begin
          // A low stop bit usually means a break; wait for the line to recover
          // instead of decoding the held-low line as a stream of 0x00 frames.
          state_d = ST_BRKWAIT;
        end else begin
          state_d     = ST_IDLE;
          idle_pend_d = 1'b1;
        end
      end

      ST_BRKWAIT: begin
        if (rxd_s) begin
          state_d     = ST_IDLE;
          idle_pend_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge b_bd_clock or negedge inRESET) begin
    if (!inRESET) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= ST_IDLE;
      phase_q     <= 2'd0;
      bit_cnt_q   <= 3'd0;
      sr_q        <= 8'h00;
      err_q       <= 1'b0;
      stop_idx_q  <= 1'b0;
      idle_pend_q <= 1'b0;
      data_q      <= 8'h00;
      frame_err_q <= 1'b0;
      data_req_q  <= 1'b0;
      idle_req_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      smp_q       <= 2'b11;
`endif
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      err_q       <= err_d;
      stop_idx_q  <= stop_idx_d;
      idle_pend_q <= idle_pend_d;
      data_q      <= data_d;
      frame_err_q <= frame_err_d;
      data_req_q  <= data_req_d;
      idle_req_q  <= idle_req_d;
      busy_q      <= busy_d;
`ifdef UART_RX_MAJORITY_EN
      smp_q       <= smp_d;
`endif
    end
  end

  assign oDATA      = data_q;
  assign oFRAME_ERR = frame_err_q;
  assign oDATA_REQ  = data_req_q;
  assign oIDLE_REQ  = idle_req_q;
  assign oBUSY      = busy_q;

endmodule
